// File: rtl/pulse_peak_detector_pkg.sv
// Shared types and default constants for the pulse peak detector.
// Contents:
//   SIZE_ADC_DATA      width of the shaped samples (two's complement)
//   PD_TS_W            width of the free-running timestamp
//   PD_MAX_RISE        default rise length before a pulse is forced out as pile-up
//   PD_DEAD_TIME       default dead time after each event
//   PD_LOST_W          default width of the lost-event counter
//   pd_state_t         detector FSM states
//   pd_event_t         one event record at default widths (amp, ts, pileup),
//                      used when packing events for the downstream FIFO
package pulse_peak_detector_pkg;

  localparam int SIZE_ADC_DATA = 16;
  localparam int PD_TS_W       = 32;
  localparam int PD_MAX_RISE   = 64;
  localparam int PD_DEAD_TIME  = 16;
  localparam int PD_LOST_W     = 16;

  typedef enum logic [1:0] {
    PD_IDLE  = 2'd0,
    PD_RISE  = 2'd1,
    PD_DEAD  = 2'd2,
    PD_REARM = 2'd3
  } pd_state_t;

  typedef struct packed {
    logic signed [SIZE_ADC_DATA-1:0] amp;
    logic        [PD_TS_W-1:0]       ts;
    logic                            pileup;
  } pd_event_t;

endpackage

// File: rtl/pulse_peak_detector_event_out.sv
// Single-entry event output register with valid/ready handshake and a
// saturating count of events that arrived while the entry was still full.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   emit                one-cycle strobe: a new event is offered
//   emit_amp/ts/pileup  fields of the offered event
//   evt_ready           consumer accepts the held event
//   evt_valid           held event available
//   evt_amp/ts/pileup   held event fields, stable while valid && !ready
//   lost_count          events dropped because the entry was full (saturating)
module pd_event_out #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 32,
  parameter int LOST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              emit,
  input  logic [DATA_W-1:0] emit_amp,
  input  logic [TS_W-1:0]   emit_ts,
  input  logic              emit_pileup,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [DATA_W-1:0] evt_amp,
  output logic [TS_W-1:0]   evt_ts,
  output logic              evt_pileup,
  output logic [LOST_W-1:0] lost_count
);

  localparam logic [LOST_W-1:0] LOST_ONE = LOST_W'(1);

  logic              valid_q,  valid_d;
  logic [DATA_W-1:0] amp_q,    amp_d;
  logic [TS_W-1:0]   ts_q,     ts_d;
  logic              pileup_q, pileup_d;
  logic [LOST_W-1:0] lost_q,   lost_d;

  // Next-state of the holding entry and the lost counter.
  always_comb begin
    valid_d  = valid_q;
    amp_d    = amp_q;
    ts_d     = ts_q;
    pileup_d = pileup_q;
    lost_d   = lost_q;
    if (emit) begin
      // An acceptance in the same cycle frees the entry, so only a held,
      // unaccepted event causes the newcomer to be dropped.
      if (valid_q && !evt_ready) begin
        if (lost_q != '1) begin
          lost_d = lost_q + LOST_ONE;
        end else begin
          lost_d = lost_q;
        end
      end else begin
        valid_d  = 1'b1;
        amp_d    = emit_amp;
        ts_d     = emit_ts;
        pileup_d = emit_pileup;
      end
    end else if (valid_q && evt_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      amp_q    <= '0;
      ts_q     <= '0;
      pileup_q <= 1'b0;
      lost_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      amp_q    <= amp_d;
      ts_q     <= ts_d;
      pileup_q <= pileup_d;
      lost_q   <= lost_d;
    end
  end

  assign evt_valid  = valid_q;
  assign evt_amp    = amp_q;
  assign evt_ts     = ts_q;
  assign evt_pileup = pileup_q;
  assign lost_count = lost_q;

endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold-triggered pulse peak detector placed after the shaping filter.
// Tracks the peak amplitude and its timestamp while a pulse rises, emits one
// event per pulse, enforces a dead time, and flags pile-up (rise timeout or
// input staying above threshold through re-arm).
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   filter_data        shaped sample, signed, one per clock
//   threshold          signed trigger level
//   enable             0 forces IDLE and suppresses capture (timestamp keeps running)
//   evt_valid/ready    event handshake towards the readout stage
//   evt_amp/ts/pileup  event fields
//   lost_count         saturating count of events dropped on a full output
//   busy               detector is not idle
module pulse_peak_detector
  import pulse_peak_detector_pkg::*;
#(
  parameter int DATA_W    = SIZE_ADC_DATA,
  parameter int TS_W      = PD_TS_W,
  parameter int MAX_RISE  = PD_MAX_RISE,
  parameter int DEAD_TIME = PD_DEAD_TIME,
  parameter int LOST_W    = PD_LOST_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic signed [DATA_W-1:0] threshold,
  input  logic                     enable,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic signed [DATA_W-1:0] evt_amp,
  output logic        [TS_W-1:0]   evt_ts,
  output logic                     evt_pileup,
  output logic        [LOST_W-1:0] lost_count,
  output logic                     busy
);

  localparam int CNT_W  = $clog2(MAX_RISE + 1);
  localparam int DCNT_W = $clog2(DEAD_TIME + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  RISE_LAST = CNT_W'(MAX_RISE - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DEAD_LAST = DCNT_W'(DEAD_TIME - 1);
  localparam logic [TS_W-1:0]   TS_ONE    = TS_W'(1);

  pd_state_t                state_q, state_d;
  logic        [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic        [TS_W-1:0]   peak_ts_q, peak_ts_d;
  logic        [CNT_W-1:0]  rise_cnt_q, rise_cnt_d;
  logic        [DCNT_W-1:0] dead_cnt_q, dead_cnt_d;
  logic        [CNT_W-1:0]  rearm_cnt_q, rearm_cnt_d;
  logic                     pend_pileup_q, pend_pileup_d;
  logic                     emit_q, emit_d;
  logic signed [DATA_W-1:0] emit_amp_q, emit_amp_d;
  logic        [TS_W-1:0]   emit_ts_q, emit_ts_d;
  logic                     emit_pileup_q, emit_pileup_d;
  logic                     busy_q, busy_d;

  logic above_s;
  logic rise_s;
  logic drop_s;

  assign above_s = filter_data > threshold;
  assign rise_s  = filter_data > max_q;
  assign drop_s  = filter_data < max_q;

  // Detector FSM, peak capture and event formation.
  always_comb begin
    state_d       = state_q;
    ts_cnt_d      = ts_cnt_q + TS_ONE;
    max_d         = max_q;
    peak_ts_d     = peak_ts_q;
    rise_cnt_d    = rise_cnt_q;
    dead_cnt_d    = dead_cnt_q;
    rearm_cnt_d   = rearm_cnt_q;
    pend_pileup_d = pend_pileup_q;
    emit_d        = 1'b0;
    emit_amp_d    = emit_amp_q;
    emit_ts_d     = emit_ts_q;
    emit_pileup_d = emit_pileup_q;
    if (!enable) begin
      state_d = PD_IDLE;
    end else begin
      case (state_q)
        PD_IDLE: begin
          if (above_s) begin
            state_d    = PD_RISE;
            max_d      = filter_data;
            peak_ts_d  = ts_cnt_q;
            rise_cnt_d = CNT_ONE;
          end else begin
            state_d = PD_IDLE;
          end
        end
        PD_RISE: begin
          // Strictly greater only: a flat top keeps the earliest timestamp.
          if (rise_s) begin
            max_d     = filter_data;
            peak_ts_d = ts_cnt_q;
          end else begin
            max_d     = max_q;
            peak_ts_d = peak_ts_q;
          end
          if (drop_s) begin
            emit_d        = 1'b1;
            emit_amp_d    = max_q;
            emit_ts_d     = peak_ts_q;
            emit_pileup_d = pend_pileup_q;
            pend_pileup_d = 1'b0;
            dead_cnt_d    = '0;
            state_d       = PD_DEAD;
          end else if (rise_cnt_q == RISE_LAST) begin
            // The timeout sample itself still counts towards the peak.
            emit_d        = 1'b1;
            emit_amp_d    = rise_s ? filter_data : max_q;
            emit_ts_d     = rise_s ? ts_cnt_q : peak_ts_q;
            emit_pileup_d = 1'b1;
            pend_pileup_d = 1'b0;
            dead_cnt_d    = '0;
            state_d       = PD_DEAD;
          end else begin
            rise_cnt_d = rise_cnt_q + CNT_ONE;
          end
        end
        PD_DEAD: begin
          if (dead_cnt_q == DEAD_LAST) begin
            if (above_s) begin
              rearm_cnt_d = '0;
              state_d     = PD_REARM;
            end else begin
              state_d = PD_IDLE;
            end
          end else begin
            dead_cnt_d = dead_cnt_q + DCNT_ONE;
          end
        end
        PD_REARM: begin
          // Staying above for a full rise window marks the next event as pile-up.
          if (!above_s) begin
            state_d = PD_IDLE;
          end else if (rearm_cnt_q == RISE_LAST) begin
            pend_pileup_d = 1'b1;
          end else begin
            rearm_cnt_d = rearm_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = PD_IDLE;
        end
      endcase
    end
    busy_d = (state_d != PD_IDLE);
  end

  // FSM, timestamp, capture and emit-stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PD_IDLE;
      ts_cnt_q      <= '0;
      max_q         <= '0;
      peak_ts_q     <= '0;
      rise_cnt_q    <= '0;
      dead_cnt_q    <= '0;
      rearm_cnt_q   <= '0;
      pend_pileup_q <= 1'b0;
      emit_q        <= 1'b0;
      emit_amp_q    <= '0;
      emit_ts_q     <= '0;
      emit_pileup_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ts_cnt_q      <= ts_cnt_d;
      max_q         <= max_d;
      peak_ts_q     <= peak_ts_d;
      rise_cnt_q    <= rise_cnt_d;
      dead_cnt_q    <= dead_cnt_d;
      rearm_cnt_q   <= rearm_cnt_d;
      pend_pileup_q <= pend_pileup_d;
      emit_q        <= emit_d;
      emit_amp_q    <= emit_amp_d;
      emit_ts_q     <= emit_ts_d;
      emit_pileup_q <= emit_pileup_d;
      busy_q        <= busy_d;
    end
  end

  assign busy = busy_q;

  pd_event_out #(
    .DATA_W(DATA_W),
    .TS_W  (TS_W),
    .LOST_W(LOST_W)
  ) u_event_out (
    .clk        (clk),
    .reset      (reset),
    .emit       (emit_q),
    .emit_amp   (emit_amp_q),
    .emit_ts    (emit_ts_q),
    .emit_pileup(emit_pileup_q),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_amp    (evt_amp),
    .evt_ts     (evt_ts),
    .evt_pileup (evt_pileup),
    .lost_count (lost_count)
  );

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Self-checking bench for pulse_peak_detector: a directed vector table,
// hand-written multi-cycle sequences, and randomized stimulus compared
// against a behavioural model of the detector.
module tb_pulse_peak_detector;
  import pulse_peak_detector_pkg::*;

  localparam int MAXR  = 64;
  localparam int DEADT = 16;
  localparam int PH_WAIT = 0, PH_CLIMB = 1, PH_DEAD = 2, PH_REARM = 3;

  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] fd;
  logic signed [15:0] thr;
  logic en;
  logic rdy;
  logic evt_valid;
  logic signed [15:0] evt_amp;
  logic [31:0] evt_ts;
  logic evt_pileup;
  logic [15:0] lost_count;
  logic busy;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pulse_peak_detector dut (
    .clk(clk), .reset(reset), .filter_data(fd), .threshold(thr), .enable(en),
    .evt_valid(evt_valid), .evt_ready(rdy), .evt_amp(evt_amp), .evt_ts(evt_ts),
    .evt_pileup(evt_pileup), .lost_count(lost_count), .busy(busy)
  );

  // ---------------- behavioural model ----------------
  int m_phase, m_peak, m_len, m_dead_left, m_rearm_above, m_lost;
  logic [31:0] m_peak_ts, m_now;
  bit m_pend, m_fire, m_full;
  pd_event_t m_fire_evt, m_held;

  task automatic model_reset();
    m_phase = PH_WAIT; m_peak = 0; m_len = 0; m_dead_left = 0; m_rearm_above = 0;
    m_lost = 0; m_peak_ts = 32'd0; m_now = 32'd0; m_pend = 1'b0; m_fire = 1'b0;
    m_full = 1'b0; m_fire_evt = '0; m_held = '0;
  endtask

  task automatic fire(input bit pu);
    m_fire = 1'b1;
    m_fire_evt.amp = 16'(m_peak);
    m_fire_evt.ts = m_peak_ts;
    m_fire_evt.pileup = pu;
    m_pend = 1'b0;
    m_phase = PH_DEAD;
    m_dead_left = DEADT;
  endtask

  // One clock of the model, given the inputs present at that edge.
  task automatic model_step(input int v, input int t, input bit e, input bit r);
    bit above;
    if (m_fire) begin
      if (m_full && !r) begin
        if (m_lost < 65535) m_lost++;
      end else begin
        m_full = 1'b1;
        m_held = m_fire_evt;
      end
    end else if (m_full && r) begin
      m_full = 1'b0;
    end
    m_fire = 1'b0;
    above = (v > t);
    if (!e) begin
      m_phase = PH_WAIT;
    end else begin
      case (m_phase)
        PH_WAIT: if (above) begin
          m_phase = PH_CLIMB; m_peak = v; m_peak_ts = m_now; m_len = 1;
        end
        PH_CLIMB: begin
          m_len++;
          if (v < m_peak) fire(m_pend);
          else begin
            if (v > m_peak) begin m_peak = v; m_peak_ts = m_now; end
            if (m_len == MAXR) fire(1'b1);
          end
        end
        PH_DEAD: begin
          m_dead_left--;
          if (m_dead_left == 0) begin
            if (above) begin m_phase = PH_REARM; m_rearm_above = 0; end
            else m_phase = PH_WAIT;
          end
        end
        PH_REARM: begin
          if (!above) m_phase = PH_WAIT;
          else begin
            m_rearm_above++;
            if (m_rearm_above >= MAXR) m_pend = 1'b1;
          end
        end
        default: m_phase = PH_WAIT;
      endcase
    end
    m_now = m_now + 32'd1;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic step();
    model_step(int'(fd), int'(thr), en, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      fd = 16'(v);
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; fd = 16'sd0; thr = 16'sd100; en = 1'b1; rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic string outs();
    return $sformatf("got valid=%0d amp=%0d ts=%0d pu=%0d lost=%0d busy=%0d",
                     evt_valid, evt_amp, evt_ts, evt_pileup, lost_count, busy);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    int fd; int thr; bit v; int amp; int ts; bit pu; bit b;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int f, input int t, input bit v, input int a,
                     input int ts, input bit pu, input bit b);
    vec_t x;
    x.fd = f; x.thr = t; x.v = v; x.amp = a; x.ts = ts; x.pu = pu; x.b = b;
    tbl.push_back(x);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n_evt, bad, cyc, mode, len, h, r, f;
    int thr_set[4];
    logic signed [15:0] cap_amp;
    logic [31:0] cap_ts;
    bit cap_pu, ok;

    // Reset state
    reset = 1'b1; fd = 16'sd0; thr = 16'sd100; en = 1'b1; rdy = 1'b1;
    #1;
    check("reset_state", evt_valid == 1'b0 && evt_amp == 16'sd0 && evt_ts == 32'd0 &&
          evt_pileup == 1'b0 && lost_count == 16'd0 && busy == 1'b0, outs());

    // Basic pulse, flat top, negative threshold
    do_reset();
    add(0, 100, 0, 0, 0, 0, 0);     add(50, 100, 0, 0, 0, 0, 0);
    add(120, 100, 0, 0, 0, 0, 1);   add(200, 100, 0, 0, 0, 0, 1);
    add(300, 100, 0, 0, 0, 0, 1);   add(250, 100, 0, 0, 0, 0, 1);
    add(100, 100, 1, 300, 4, 0, 1); add(0, 100, 0, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) add(0, 100, 0, 0, 0, 0, 1);
    add(0, 100, 0, 0, 0, 0, 0);
    add(150, 100, 0, 0, 0, 0, 1);   add(300, 100, 0, 0, 0, 0, 1);
    add(300, 100, 0, 0, 0, 0, 1);   add(300, 100, 0, 0, 0, 0, 1);
    add(200, 100, 0, 0, 0, 0, 1);   add(0, 100, 1, 300, 23, 0, 1);
    add(0, 100, 0, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) add(0, 100, 0, 0, 0, 0, 1);
    add(0, 100, 0, 0, 0, 0, 0);
    add(-100, -50, 0, 0, 0, 0, 0);  add(-60, -50, 0, 0, 0, 0, 0);
    add(-40, -50, 0, 0, 0, 0, 1);   add(-10, -50, 0, 0, 0, 0, 1);
    add(-30, -50, 0, 0, 0, 0, 1);   add(-100, -50, 1, -10, 46, 0, 1);
    add(-100, -50, 0, 0, 0, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      fd = 16'(tbl[i].fd); thr = 16'(tbl[i].thr);
      step();
      ok = (evt_valid == tbl[i].v) && (busy == tbl[i].b) && (lost_count == 16'd0) &&
           (!tbl[i].v || (int'(evt_amp) == tbl[i].amp && evt_ts == 32'(tbl[i].ts) &&
                          evt_pileup == tbl[i].pu));
      check($sformatf("vec%0d", i), ok, $sformatf("%s want valid=%0d amp=%0d ts=%0d pu=%0d busy=%0d",
            outs(), tbl[i].v, tbl[i].amp, tbl[i].ts, tbl[i].pu, tbl[i].b));
    end

    // Timeout: ramp 101..200, one pile-up event with amp 164 at ts 63
    do_reset();
    n_evt = 0; cap_amp = '0; cap_ts = '0; cap_pu = 1'b0;
    for (int i = 0; i < 100; i++) begin
      fd = 16'(101 + i);
      step();
      if (evt_valid) begin
        if (n_evt == 0) begin cap_amp = evt_amp; cap_ts = evt_ts; cap_pu = evt_pileup; end
        n_evt++;
      end
    end
    check("timeout_count", n_evt == 1, $sformatf("got %0d events want 1", n_evt));
    check("timeout_event", cap_amp == 16'sd164 && cap_ts == 32'd63 && cap_pu == 1'b1,
          $sformatf("got amp=%0d ts=%0d pu=%0d want 164/63/1", cap_amp, cap_ts, cap_pu));
    check("timeout_rearm_busy", busy == 1'b1 && evt_valid == 1'b0, outs());
    feed(100, 1);
    check("timeout_rearm_exit", busy == 1'b0 && evt_valid == 1'b0, outs());

    // Backpressure: first event held, second dropped
    do_reset();
    rdy = 1'b0;
    feed(0, 1); feed(200, 1); feed(300, 1); feed(250, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      feed(0, 1);
      if (!(evt_valid && evt_amp == 16'sd300 && evt_ts == 32'd2 && !evt_pileup)) bad++;
    end
    check("bp_hold_stable", bad == 0, $sformatf("%0d unstable cycles want 0", bad));
    feed(200, 1); feed(400, 1); feed(300, 1); feed(0, 3);
    check("bp_lost", lost_count == 16'd1, outs());
    check("bp_held_first", evt_valid && evt_amp == 16'sd300 && evt_ts == 32'd2, outs());
    rdy = 1'b1;
    feed(0, 1);
    check("bp_after_accept", !evt_valid && lost_count == 16'd1, outs());

    // Asynchronous reset mid-RISE with a held event and a lost count
    do_reset();
    rdy = 1'b0;
    feed(200, 1); feed(300, 1); feed(250, 1); feed(0, 20);
    feed(200, 1); feed(300, 1); feed(250, 1); feed(0, 20);
    feed(150, 1); feed(200, 1);
    check("pre_reset", evt_valid && lost_count == 16'd1 && busy, outs());
    #3 reset = 1'b1;
    #1;
    check("async_reset", evt_valid == 1'b0 && evt_amp == 16'sd0 && evt_ts == 32'd0 &&
          evt_pileup == 1'b0 && lost_count == 16'd0 && busy == 1'b0, outs());

    // Enable low: no capture, no busy; deassert mid-RISE aborts
    do_reset();
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      feed((i == 1) ? 200 : (i == 2) ? 300 : (i == 3) ? 250 : 0, 1);
      if (busy || evt_valid) bad++;
    end
    check("enable_off", bad == 0, $sformatf("%0d active cycles want 0", bad));
    en = 1'b1;
    feed(150, 1); feed(200, 1);
    check("enable_rise_busy", busy == 1'b1, outs());
    en = 1'b0;
    feed(300, 1);
    check("enable_abort", busy == 1'b0, outs());
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      feed(0, 1);
      if (evt_valid) bad++;
    end
    check("enable_abort_no_event", bad == 0, $sformatf("%0d valid cycles want 0", bad));

    // Randomized stimulus against the model
    do_reset();
    thr_set[0] = 100; thr_set[1] = -50; thr_set[2] = 0; thr_set[3] = 300;
    cyc = 0;
    while (cyc < 4000) begin
      mode = int'($urandom_range(0, 3));
      thr = 16'(thr_set[$urandom_range(0, 3)]);
      h = int'($urandom_range(1, 400));
      r = int'($urandom_range(1, 10));
      f = int'($urandom_range(1, 10));
      len = (mode == 0) ? int'($urandom_range(5, 30)) :
            (mode == 3) ? int'($urandom_range(30, 160)) : r + f;
      for (int i = 0; i < len; i++) begin
        case (mode)
          0: fd = 16'(int'(thr) - 150 + int'($urandom_range(0, 200)));
          3: fd = 16'(int'(thr) + 10 + h % 4);
          default: fd = (i < r) ? 16'(int'(thr) - 20 + ((h + 20) * (i + 1)) / r)
                                : 16'(int'(thr) + h - ((h + 40) * (i - r + 1)) / f);
        endcase
        en = ($urandom_range(0, 199) != 0);
        rdy = ($urandom_range(0, 9) < 7);
        step();
        ok = (evt_valid == m_full) && (lost_count == 16'(m_lost)) &&
             (busy == (m_phase != PH_WAIT)) &&
             (!m_full || (evt_amp == m_held.amp && evt_ts == m_held.ts &&
                          evt_pileup == m_held.pileup));
        check($sformatf("rand%0d", cyc), ok, $sformatf("%s want valid=%0d amp=%0d ts=%0d pu=%0d lost=%0d busy=%0d",
              outs(), m_full, m_held.amp, m_held.ts, m_held.pileup, m_lost, m_phase != PH_WAIT));
        cyc++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
